// File: rtl/sat_round_fp_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sat_round_fp_pipe_pkg
// Description : Rounding-mode encodings and width helpers for the requantizer.
// Revision    : 1.0 - initial release
// ============================================================================
package sat_round_fp_pipe_pkg;

    localparam logic [1:0] RND_TRUNC   = 2'd0;
    localparam logic [1:0] RND_HALF_UP = 2'd1;
    localparam logic [1:0] RND_CONV    = 2'd2;

    function automatic int calc_nbi(input int nb, input int nbf);
        return nb - nbf;
    endfunction

    function automatic int calc_d(input int nbf_xi, input int nbf_xo);
        return nbf_xi - nbf_xo;
    endfunction

    // Sign-extended input after dropping D fraction bits (or padding -D of them)
    function automatic int calc_nb_rnd(input int nb_xi, input int nbf_xi, input int nbf_xo);
        return nb_xi + 1 - calc_d(nbf_xi, nbf_xo);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_round_sat_lane.sv
`default_nettype none
// ============================================================================
// Module      : fp_round_sat_lane
// Description : One lane: combinational rounding half and range (sat/wrap) half.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_round_sat_lane
    import sat_round_fp_pipe_pkg::*;
#(
    parameter int NB_XI  = 32,
    parameter int NBF_XI = 30,
    parameter int NB_XO  = 16,
    parameter int NBF_XO = 15
) (
    input  logic [NB_XI-1:0]                                     i_x,
    input  logic [1:0]                                           i_rnd_mode,
    output logic [calc_nb_rnd(NB_XI, NBF_XI, NBF_XO)-1:0]        o_rnd,
    input  logic [calc_nb_rnd(NB_XI, NBF_XI, NBF_XO)-1:0]        i_rnd,
    input  logic                                                 i_sat_en,
    output logic [NB_XO:0]                                       o_res
);

    localparam int c_d    = calc_d(NBF_XI, NBF_XO);
    localparam int c_nb_r = calc_nb_rnd(NB_XI, NBF_XI, NBF_XO);

    logic [NB_XI:0] w_ext;
    assign w_ext = {i_x[NB_XI-1], i_x};

    generate
        if (c_d > 0) begin : g_round
            localparam logic [c_d-1:0] c_half = c_d'(1) << (c_d - 1);
            logic [c_d-1:0] w_add;
            logic           w_carry;

            always_comb begin
                w_add = '0;
                case (i_rnd_mode)
                    RND_HALF_UP: w_add = c_half;
                    RND_CONV:    w_add = c_half - c_d'(1) + c_d'(i_x[c_d]);
                    default:     w_add = '0;
                endcase
            end

            // Carry out of the discarded bits: lo + add >= 2^D  <=>  lo > ~add
            assign w_carry = (w_ext[c_d-1:0] > ~w_add);
            assign o_rnd   = w_ext[NB_XI:c_d] + {{(c_nb_r-1){1'b0}}, w_carry};
        end else if (c_d == 0) begin : g_pass
            assign o_rnd = w_ext;
        end else begin : g_pad
            assign o_rnd = {w_ext, {(-c_d){1'b0}}};
        end
    endgenerate

    generate
        if (c_nb_r > NB_XO) begin : g_range
            logic [c_nb_r-NB_XO:0] w_hi;
            logic                  w_ovf;
            logic                  w_neg;
            logic [NB_XO-1:0]      w_sat;

            assign w_hi  = i_rnd[c_nb_r-1:NB_XO-1];
            assign w_ovf = !((&w_hi) || !(|w_hi));
            assign w_neg = i_rnd[c_nb_r-1];
            assign w_sat = w_neg ? {1'b1, {(NB_XO-1){1'b0}}} : {1'b0, {(NB_XO-1){1'b1}}};
            assign o_res = {w_ovf, (w_ovf && i_sat_en) ? w_sat : i_rnd[NB_XO-1:0]};
        end else if (c_nb_r == NB_XO) begin : g_same
            assign o_res = {1'b0, i_rnd};
        end else begin : g_extend
            assign o_res = {1'b0, {(NB_XO-c_nb_r){i_rnd[c_nb_r-1]}}, i_rnd};
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/sat_round_fp_pipe.sv
`default_nettype none
// ============================================================================
// Module      : sat_round_fp_pipe
// Description : Two-stage multi-lane requantizer with valid/ready and overflow stats.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_round_fp_pipe
    import sat_round_fp_pipe_pkg::*;
#(
    parameter int NB_XI  = 32,
    parameter int NBF_XI = 30,
    parameter int NB_XO  = 16,
    parameter int NBF_XO = 15,
    parameter int N_CH   = 1,
    parameter int NB_CNT = 16
) (
    input  logic                    clk,
    input  logic                    i_rst_n,
    input  logic [N_CH*NB_XI-1:0]   i_data,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [1:0]              i_rnd_mode,
    input  logic                    i_sat_en,
    output logic [N_CH*NB_XO-1:0]   o_data,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [N_CH-1:0]         o_ovf,
    output logic                    o_ovf_sticky,
    input  logic                    i_ovf_clr,
    output logic [NB_CNT-1:0]       o_ovf_cnt
);

    localparam int c_nb_r = calc_nb_rnd(NB_XI, NBF_XI, NBF_XO);

    logic                      r_s1_valid;
    logic [N_CH*c_nb_r-1:0]    r_s1_rnd;
    logic                      r_s1_sat;
    logic                      r_s2_valid;
    logic [N_CH*NB_XO-1:0]     r_s2_data;
    logic [N_CH-1:0]           r_s2_ovf;
    logic                      r_sticky;
    logic [NB_CNT-1:0]         r_cnt;

    logic                      w_s2_adv;
    logic                      w_s1_adv;
    logic                      w_in_ready;
    logic [N_CH*c_nb_r-1:0]    w_rnd;
    logic [N_CH*NB_XO-1:0]     w_data;
    logic [N_CH-1:0]           w_ovf;

    assign w_s2_adv   = !r_s2_valid || i_ready;
    assign w_s1_adv   = w_s2_adv;
    assign w_in_ready = !r_s1_valid || w_s1_adv;

    generate
        for (genvar k = 0; k < N_CH; k++) begin : g_lane
            logic [NB_XO:0] w_res;

            fp_round_sat_lane #(
                .NB_XI  (NB_XI),
                .NBF_XI (NBF_XI),
                .NB_XO  (NB_XO),
                .NBF_XO (NBF_XO)
            ) u_lane (
                .i_x        (i_data[k*NB_XI +: NB_XI]),
                .i_rnd_mode (i_rnd_mode),
                .o_rnd      (w_rnd[k*c_nb_r +: c_nb_r]),
                .i_rnd      (r_s1_rnd[k*c_nb_r +: c_nb_r]),
                .i_sat_en   (r_s1_sat),
                .o_res      (w_res)
            );

            assign w_ovf[k]                  = w_res[NB_XO];
            assign w_data[k*NB_XO +: NB_XO]  = w_res[NB_XO-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_rnd   <= '0;
            r_s1_sat   <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_ovf   <= '0;
        end else begin
            if (w_in_ready) begin
                r_s1_valid <= i_valid;
                if (i_valid) begin
                    r_s1_rnd <= w_rnd;
                    r_s1_sat <= i_sat_en;
                end
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_data <= w_data;
                    r_s2_ovf  <= w_ovf;
                end
            end
        end
    end

    // Clear wins over a same-cycle overflow handshake
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_sticky <= 1'b0;
            r_cnt    <= '0;
        end else if (i_ovf_clr) begin
            r_sticky <= 1'b0;
            r_cnt    <= '0;
        end else if (r_s2_valid && i_ready && (|r_s2_ovf)) begin
            r_sticky <= 1'b1;
            if (!(&r_cnt)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_ready      = w_in_ready;
    assign o_valid      = r_s2_valid;
    assign o_data       = r_s2_data;
    assign o_ovf        = r_s2_ovf;
    assign o_ovf_sticky = r_sticky;
    assign o_ovf_cnt    = r_cnt;

endmodule
`default_nettype wire
